// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types and constants for the two-port Avalon-MM bus arbiter.
//   arb_state_t    : arbiter ownership state
//   ARB_GRANT_*    : one-hot grant encodings driven on the grant output
//   arb_cnt_w_ok() : true when a CNT_W-bit counter can hold TIMEOUT_CYCLES
package avalon_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] ARB_GRANT_NONE = 2'b00;
  localparam logic [1:0] ARB_GRANT_0    = 2'b01;
  localparam logic [1:0] ARB_GRANT_1    = 2'b10;

  function automatic bit arb_cnt_w_ok(input int cnt_w, input int timeout_cycles);
    return (64'd1 << cnt_w) > 64'(timeout_cycles);
  endfunction

endpackage

// File: rtl/avalon_bus_arbiter_timeout_counter.sv
// Stalled-slave timeout counter for the bus arbiter.
//   clk, reset : clock and synchronous active-high reset
//   en         : owner is waiting on the slave this cycle
//   clr        : return the count to zero (no transfer in flight or transfer ending)
//   expired    : count has reached TIMEOUT_CYCLES while still waiting
// The count saturates at TIMEOUT_CYCLES; TIMEOUT_CYCLES == 0 disables expiry.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && en && (count == LIMIT);

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-port Avalon-MM arbiter sharing the MIPS core's single bus master.
//   Port 0 (m0_*) : instruction fetch requester
//   Port 1 (m1_*) : data load/store requester
//   Slave side    : address/read/write/writedata/byteenable out, waitrequest/readdata in
//   grant         : one-hot owner (01 port 0, 10 port 1, 00 none)
//   bus_timeout   : sticky stalled-slave error, cleared only by reset
// A granted port keeps the bus until its transfer completes, its request drops,
// or the slave stalls for TIMEOUT_CYCLES; every transfer is followed by one
// IDLE cycle in which the next owner is chosen.
module avalon_bus_arbiter
  import avalon_bus_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [1:0]  grant,
  output logic        bus_timeout
);

  if (!arb_cnt_w_ok(CNT_W, TIMEOUT_CYCLES)) begin : g_cnt_w_check
    $error("CNT_W too small to hold TIMEOUT_CYCLES");
  end

  arb_state_t state, state_nx;
  logic       last_owner;
  logic       req0, req1;
  logic       owning, owner_req;
  logic       cnt_en, cnt_clr, timeout_hit, xfer_end;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign owning    = (state == ARB_OWN0) || (state == ARB_OWN1);
  assign owner_req = (state == ARB_OWN1) ? req1 : req0;

  // A dropped request ends the transfer outright, so it never counts toward a timeout.
  assign cnt_en   = owning & waitrequest & owner_req;
  assign xfer_end = owning & (~waitrequest | ~owner_req | timeout_hit);
  assign cnt_clr  = ~owning | xfer_end;

  arb_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .expired (timeout_hit)
  );

  // Stage boundary: ownership state, round-robin history and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      last_owner  <= 1'b1;
      bus_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (xfer_end) begin
        last_owner <= (state == ARB_OWN1);
      end
      if (timeout_hit) begin
        bus_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nx       = state;
    address        = '0;
    read           = 1'b0;
    write          = 1'b0;
    writedata      = '0;
    byteenable     = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (state)
      ARB_IDLE: begin
        if (req0 && req1) begin
          state_nx = ((FIXED_PRIORITY != 0) || (last_owner == 1'b0)) ? ARB_OWN1 : ARB_OWN0;
        end else if (req0) begin
          state_nx = ARB_OWN0;
        end else if (req1) begin
          state_nx = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        address        = m0_address;
        read           = m0_read;
        write          = m0_write;
        writedata      = m0_writedata;
        byteenable     = m0_byteenable;
        m0_waitrequest = waitrequest & ~timeout_hit;
      end
      ARB_OWN1: begin
        address        = m1_address;
        read           = m1_read;
        write          = m1_write;
        writedata      = m1_writedata;
        byteenable     = m1_byteenable;
        m1_waitrequest = waitrequest & ~timeout_hit;
      end
      default: state_nx = ARB_IDLE;
    endcase
    if (xfer_end) begin
      state_nx = ARB_IDLE;
    end
  end

  assign m0_readdata = readdata;
  assign m1_readdata = readdata;

  always_comb begin
    case (state)
      ARB_OWN0: grant = ARB_GRANT_0;
      ARB_OWN1: grant = ARB_GRANT_1;
      default:  grant = ARB_GRANT_NONE;
    endcase
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: a round-robin and a fixed-priority instance
// share one stimulus stream (directed scenarios, then random traffic) and are
// compared every cycle against a transaction-level reference model.
module tb_avalon_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  logic        rr_m0_wr, rr_m1_wr, fp_m0_wr, fp_m1_wr;
  logic [31:0] rr_m0_rd, rr_m1_rd, fp_m0_rd, fp_m1_rd;
  logic [31:0] rr_address, fp_address, rr_writedata, fp_writedata;
  logic        rr_read, rr_write, fp_read, fp_write;
  logic [3:0]  rr_be, fp_be;
  logic [1:0]  rr_grant, fp_grant;
  logic        rr_to, fp_to;

  always #5 clk = ~clk;

  avalon_bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(rr_m0_wr), .m0_readdata(rr_m0_rd),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(rr_m1_wr), .m1_readdata(rr_m1_rd),
    .address(rr_address), .read(rr_read), .write(rr_write),
    .writedata(rr_writedata), .byteenable(rr_be),
    .waitrequest(waitrequest), .readdata(readdata),
    .grant(rr_grant), .bus_timeout(rr_to)
  );

  avalon_bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(fp_m0_wr), .m0_readdata(fp_m0_rd),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(fp_m1_wr), .m1_readdata(fp_m1_rd),
    .address(fp_address), .read(fp_read), .write(fp_write),
    .writedata(fp_writedata), .byteenable(fp_be),
    .waitrequest(waitrequest), .readdata(readdata),
    .grant(fp_grant), .bus_timeout(fp_to)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model, one per instance (0 = round-robin, 1 = fixed priority).
  // owner -1 means no transfer in flight; waited counts stalled cycles of it.
  int m_owner[2] = '{-1, -1};
  int m_last[2]  = '{1, 1};
  int m_wait[2]  = '{0, 0};
  bit m_tmo[2]   = '{1'b0, 1'b0};
  logic rr_ew0, rr_ew1;

  function automatic bit port_req(input int p);
    return (p == 0) ? (m0_read | m0_write) : (m1_read | m1_write);
  endfunction

  function automatic bit model_hit(input int d);
    if (m_owner[d] < 0) return 1'b0;
    return (m_wait[d] >= TO) && waitrequest && port_req(m_owner[d]);
  endfunction

  task automatic compare_dut(input int d, input string p,
                             input logic [1:0] o_gnt, input logic o_to,
                             input logic [31:0] o_addr, input logic o_rd, input logic o_wr,
                             input logic [31:0] o_wd, input logic [3:0] o_be,
                             input logic o_w0, input logic o_w1,
                             input logic [31:0] o_rd0, input logic [31:0] o_rd1,
                             output logic e_w0, output logic e_w1);
    logic [31:0] e_addr, e_wd;
    logic        e_rd, e_wr;
    logic [3:0]  e_be;
    logic [1:0]  e_gnt;
    e_addr = '0; e_wd = '0; e_rd = 1'b0; e_wr = 1'b0; e_be = '0; e_gnt = 2'b00;
    e_w0 = 1'b1; e_w1 = 1'b1;
    if (m_owner[d] == 0) begin
      e_gnt = 2'b01; e_addr = m0_address; e_wd = m0_writedata;
      e_rd = m0_read; e_wr = m0_write; e_be = m0_byteenable;
      e_w0 = waitrequest && !model_hit(d);
    end else if (m_owner[d] == 1) begin
      e_gnt = 2'b10; e_addr = m1_address; e_wd = m1_writedata;
      e_rd = m1_read; e_wr = m1_write; e_be = m1_byteenable;
      e_w1 = waitrequest && !model_hit(d);
    end
    chk({p, ".grant"}, 32'(o_gnt), 32'(e_gnt));
    chk({p, ".bus_timeout"}, 32'(o_to), 32'(m_tmo[d]));
    chk({p, ".address"}, o_addr, e_addr);
    chk({p, ".read"}, 32'(o_rd), 32'(e_rd));
    chk({p, ".write"}, 32'(o_wr), 32'(e_wr));
    chk({p, ".writedata"}, o_wd, e_wd);
    chk({p, ".byteenable"}, 32'(o_be), 32'(e_be));
    chk({p, ".m0_waitrequest"}, 32'(o_w0), 32'(e_w0));
    chk({p, ".m1_waitrequest"}, 32'(o_w1), 32'(e_w1));
    chk({p, ".m0_readdata"}, o_rd0, readdata);
    chk({p, ".m1_readdata"}, o_rd1, readdata);
  endtask

  task automatic advance(input int d);
    bit r0, r1, hit;
    r0 = port_req(0);
    r1 = port_req(1);
    if (reset) begin
      m_owner[d] = -1; m_last[d] = 1; m_wait[d] = 0; m_tmo[d] = 1'b0;
    end else if (m_owner[d] < 0) begin
      if (r0 && r1)  m_owner[d] = (d == 1) ? 1 : 1 - m_last[d];
      else if (r0)   m_owner[d] = 0;
      else if (r1)   m_owner[d] = 1;
    end else begin
      hit = model_hit(d);
      if (!waitrequest || !port_req(m_owner[d]) || hit) begin
        m_last[d]  = m_owner[d];
        m_owner[d] = -1;
        m_wait[d]  = 0;
        if (hit) m_tmo[d] = 1'b1;
      end else if (m_wait[d] < TO) begin
        m_wait[d]++;
      end
    end
  endtask

  task automatic step();
    logic ew0, ew1;
    @(negedge clk);
    compare_dut(0, "rr", rr_grant, rr_to, rr_address, rr_read, rr_write, rr_writedata, rr_be,
                rr_m0_wr, rr_m1_wr, rr_m0_rd, rr_m1_rd, rr_ew0, rr_ew1);
    compare_dut(1, "fp", fp_grant, fp_to, fp_address, fp_read, fp_write, fp_writedata, fp_be,
                fp_m0_wr, fp_m1_wr, fp_m0_rd, fp_m1_rd, ew0, ew1);
    advance(0);
    advance(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = wd; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = wd; m1_byteenable = be;
    end
  endtask

  task automatic do_reset();
    set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_port(1, 0, 0, 32'h0, 32'h0, 4'h0);
    waitrequest = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  bit          act[2];
  bit          done_p[2];
  int          stuck;

  initial begin
    reset = 1'b1;
    readdata = 32'h0;
    set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_port(1, 0, 0, 32'h0, 32'h0, 4'h0);
    waitrequest = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single fetch: two stalled cycles then completion with the opcode.
    set_port(0, 1, 0, 32'hBFC00000, 32'h0, 4'hF);
    readdata = 32'h3C021234;
    waitrequest = 1'b1;
    repeat (3) step();
    waitrequest = 1'b0;
    step();
    set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
    repeat (2) step();

    // Continuous tie with a zero-wait slave.
    do_reset();
    set_port(0, 1, 0, 32'h00001000, 32'h0, 4'hF);
    set_port(1, 1, 0, 32'h80002000, 32'h0, 4'hF);
    waitrequest = 1'b0;
    readdata = 32'h12345678;
    repeat (9) step();

    // Port 1 write held locked while port 0 asks mid-transfer.
    do_reset();
    set_port(1, 0, 1, 32'h80000040, 32'hDEADBEEF, 4'b1100);
    waitrequest = 1'b1;
    step();
    set_port(0, 1, 0, 32'h00000400, 32'h0, 4'hF);
    repeat (5) step();
    waitrequest = 1'b0;
    step();
    set_port(1, 0, 0, 32'h0, 32'h0, 4'h0);
    repeat (3) step();
    set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
    step();

    // Stuck slave, then normal traffic with the error flag still set.
    do_reset();
    set_port(0, 1, 0, 32'h00000800, 32'h0, 4'hF);
    waitrequest = 1'b1;
    repeat (11) step();
    set_port(0, 0, 0, 32'h0, 32'h0, 4'h0);
    set_port(1, 0, 1, 32'h80000010, 32'hCAFEF00D, 4'hF);
    waitrequest = 1'b0;
    repeat (6) step();

    // Reset during a stalled port 1 write, then a tie.
    do_reset();
    set_port(1, 0, 1, 32'h80000020, 32'h55AA55AA, 4'h3);
    waitrequest = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_port(0, 1, 0, 32'h00000100, 32'h0, 4'hF);
    set_port(1, 1, 0, 32'h80000100, 32'h0, 4'hF);
    waitrequest = 1'b0;
    repeat (4) step();

    // Random traffic: requesters hold until the round-robin instance releases them.
    do_reset();
    act = '{1'b0, 1'b0};
    done_p = '{1'b0, 1'b0};
    stuck = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (stuck > 0) begin
        waitrequest = 1'b1;
        stuck--;
      end else begin
        waitrequest = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 39) == 0) stuck = $urandom_range(6, 12);
      end
      readdata = $urandom;
      for (int p = 0; p < 2; p++) begin
        if (!act[p] || done_p[p] || $urandom_range(0, 59) == 0) begin
          if ($urandom_range(0, 2) != 0) begin
            act[p] = 1'b1;
            if ($urandom_range(0, 1) == 0) set_port(p, 1, 0, $urandom, $urandom, 4'($urandom));
            else                           set_port(p, 0, 1, $urandom, $urandom, 4'($urandom));
          end else begin
            act[p] = 1'b0;
            set_port(p, 0, 0, $urandom, $urandom, 4'($urandom));
          end
        end
      end
      step();
      done_p[0] = act[0] && !rr_ew0;
      done_p[1] = act[1] && !rr_ew1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_bus_arbiter.md
Name: avalon_bus_arbiter

Overview:
- Shares the single Avalon memory-mapped master port of the MIPS core between two requesters.
  - Port 0 is instruction fetch.
  - Port 1 is data load/store.
- Sits between the CPU-side request logic and the external bus.
- Per-port Avalon semantics are unchanged: a requester holds its read/write until its waitrequest drops.
- Adds grant locking, selectable round-robin or fixed priority, and a stalled-slave timeout with a sticky error flag.

Parameters:
- FIXED_PRIORITY, 0: 0 selects round-robin; 1 means port 1 (data) always wins ties.
- TIMEOUT_CYCLES, 1024: number of consecutive slave waitrequest-high cycles, within one granted transfer, that triggers an abort; 0 disables the timeout.
- CNT_W, 11: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_address  in  32  port 0 word address.
- m0_read  in  1  port 0 read request.
- m0_write  in  1  port 0 write request.
- m0_writedata  in  32  port 0 write data.
- m0_byteenable  in  4  port 0 byte enables.
- m0_waitrequest  out  1  port 0 stall.
- m0_readdata  out  32  port 0 read data.
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_waitrequest, m1_readdata: same widths, directions and meanings as the m0 ports, for port 1.
- address  out  32  slave-side address.
- read  out  1  slave-side read.
- write  out  1  slave-side write.
- writedata  out  32  slave-side write data.
- byteenable  out  4  slave-side byte enables.
- waitrequest  in  1  slave-side stall.
- readdata  in  32  slave-side read data.
- grant  out  2  one-hot current owner: 01 = port 0, 10 = port 1, 00 = none.
- bus_timeout  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Request definition: req_n = mn_read | mn_write. Asserting read and write together on one port is illegal. The arbiter forwards both unchanged and does not check.
- FSM states: IDLE, OWN0, OWN1.
  - Registered state: last_owner (1 bit) and a timeout counter.
- IDLE:
  - Slave read, write and byteenable are driven 0.
  - Both mn_waitrequest outputs are 1.
  - Next state comes from req0/req1:
    - Neither requesting: stay in IDLE.
    - One requesting: move to that port's OWN state.
    - Both requesting, FIXED_PRIORITY=1: go to OWN1.
    - Both requesting, FIXED_PRIORITY=0: grant the port that is not last_owner.
  - Arbitration latency: one cycle from request to the slave seeing it.
- OWNn:
  - Slave address, read, write, writedata and byteenable are combinationally driven from port n.
  - mn_waitrequest = waitrequest.
  - The other port's waitrequest is forced to 1.
  - Both mn_readdata outputs = readdata. A value is only meaningful to the owner on a completion cycle.
- Completion: in OWNn, the first cycle with waitrequest=0 completes the transfer.
  - Next state is IDLE; last_owner <= n; counter <= 0.
  - There is always one idle bubble cycle between consecutive transfers, even from the same port.
- Owner drops its request mid-transfer: that is illegal Avalon behaviour, treated as a completion. Return to IDLE; the slave sees read/write fall that cycle.
- Timeout, when TIMEOUT_CYCLES != 0:
  - The counter increments on every OWNn cycle with waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES and waitrequest is still 1:
    - That cycle, force mn_waitrequest=0 for the owner.
    - The owner's readdata is that cycle's readdata (don't-care).
    - Set bus_timeout <= 1; next state IDLE; last_owner <= n; counter <= 0.
  - Completion and timeout in the same cycle: completion wins; bus_timeout is unchanged.
- Counter saturates at TIMEOUT_CYCLES and never wraps. It resets to 0 on every entry to IDLE.
- Reset, including reset asserted mid-transfer:
  - Next state IDLE; last_owner <= 1, so port 0 wins the first tie; counter <= 0; bus_timeout <= 0.
  - After reset: grant=00, read=0, write=0, byteenable=0, address=0, writedata=0, both mn_waitrequest=1.
  - A transfer interrupted by reset is abandoned; the slave sees read/write fall in the cycle after reset is sampled.
- grant is decoded from state: OWN0 gives 01, OWN1 gives 10, IDLE gives 00.
- Outputs in IDLE are fixed at 0 and do not hold stale values.

Decomposition:
- Shared package entries:
  - typedef arb_state_t {ARB_IDLE, ARB_OWN0, ARB_OWN1}.
  - Constants ARB_GRANT_NONE/0/1 (2-bit one-hot).
  - Parameter-check constant for CNT_W.
- One natural sub-module, arb_timeout_counter: enable, clear, saturating compare to TIMEOUT_CYCLES, and an expired pulse output.
- Datapath muxing stays in the top-level module.

Test Plan:
- Single fetch: m0_read=1, address 0xBFC00000, slave waitrequest=1 for 2 cycles then 0, readdata 0x3C021234 → grant=01 from cycle 1; m0_waitrequest falls on cycle 3 with m0_readdata=0x3C021234; m1_waitrequest stays 1 throughout.
- Round-robin tie (FIXED_PRIORITY=0): both ports request continuously from reset, slave zero-wait → grant sequence 01, 00, 10, 00, 01, 00, 10.
- Fixed priority (FIXED_PRIORITY=1): same stimulus → grant 10, 00, 10, 00, ...; port 0 is starved while port 1 keeps requesting.
- Lock on write: OWN1 with m1_write=1, writedata=0xDEADBEEF, byteenable=1100; port 0 raises read mid-transfer; slave waitrequest held high 5 cycles → slave lines stay on port 1 values until completion; port 0 is granted only after the IDLE bubble.
- Timeout (TIMEOUT_CYCLES=8): port 0 reads, slave waitrequest stuck at 1 → m0_waitrequest pulses 0 exactly 8 cycles after grant; bus_timeout=1 and stays 1 across later normal transfers until reset.
- Reset mid-transfer: assert reset during OWN1 with waitrequest=1 → next cycle grant=00, write=0, bus_timeout=0; after release, a tie grants port 0 first.
